div_arbiter: RTL and testbench

- Shares one ZipCPU-protocol integer divide unit between two requesters, A and B. Typical pair: a CPU core and a DSP/DMA helper.
- Each requester sees a divider-shaped slave port (i_wr/o_busy/o_valid/o_err/o_quotient/o_flags).
- Requests are latched, arbitrated round-robin and issued one at a time to the shared divider.
- A watchdog returns an error if the divider never completes.

---
 rtl/div_arb_pkg.sv | 41 ++++
 rtl/div_req_slot.sv | 53 +++++
 rtl/div_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_div_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_arb_pkg
// Description : Shared types and helpers for the two-port divider arbiter.
// Revision    : 1.0
// ============================================================================
package div_arb_pkg;

    localparam int DIV_FLAGS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    // With both pending, the favoured requester is the one not served last.
    function automatic owner_e rr_pick(
        input logic   a_pend,
        input logic   b_pend,
        input owner_e favour
    );
        if (a_pend && b_pend)
            return favour;
        else if (b_pend)
            return OWNER_B;
        else
            return OWNER_A;
    endfunction

    function automatic owner_e other_owner(input owner_e who);
        return (who == OWNER_A) ? OWNER_B : OWNER_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_req_slot.sv
`default_nettype none
// ============================================================================
// Module      : div_req_slot
// Description : Per-requester holding register: pending flag plus operands.
// Revision    : 1.0
// ============================================================================
module div_req_slot
    import div_arb_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic          i_clear,
    input  logic          i_signed,
    input  logic [BW-1:0] i_numerator,
    input  logic [BW-1:0] i_denominator,
    output logic          o_busy,
    output logic          o_signed,
    output logic [BW-1:0] o_numerator,
    output logic [BW-1:0] o_denominator
);

    logic          r_pend;
    logic          r_signed;
    logic [BW-1:0] r_numerator;
    logic [BW-1:0] r_denominator;

    // Operands only load while idle, so they stay stable for the whole issue.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend        <= 1'b0;
            r_signed      <= 1'b0;
            r_numerator   <= '0;
            r_denominator <= '0;
        end else if (i_wr && !r_pend) begin
            r_pend        <= 1'b1;
            r_signed      <= i_signed;
            r_numerator   <= i_numerator;
            r_denominator <= i_denominator;
        end else if (i_clear) begin
            r_pend        <= 1'b0;
        end
    end

    assign o_busy        = r_pend;
    assign o_signed      = r_signed;
    assign o_numerator   = r_numerator;
    assign o_denominator = r_denominator;

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Round-robin sharing of one divide unit between two requesters.
// Revision    : 1.0
// ============================================================================
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int BW      = 32,
    parameter int TIMEOUT = 64,
    parameter int LGTO    = 7
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_a_wr,
    input  logic                   i_a_signed,
    input  logic [BW-1:0]          i_a_numerator,
    input  logic [BW-1:0]          i_a_denominator,
    output logic                   o_a_busy,
    output logic                   o_a_valid,
    output logic                   o_a_err,
    output logic [BW-1:0]          o_a_quotient,
    output logic [DIV_FLAGS_W-1:0] o_a_flags,
    input  logic                   i_b_wr,
    input  logic                   i_b_signed,
    input  logic [BW-1:0]          i_b_numerator,
    input  logic [BW-1:0]          i_b_denominator,
    output logic                   o_b_busy,
    output logic                   o_b_valid,
    output logic                   o_b_err,
    output logic [BW-1:0]          o_b_quotient,
    output logic [DIV_FLAGS_W-1:0] o_b_flags,
    output logic                   o_div_wr,
    output logic                   o_div_signed,
    output logic [BW-1:0]          o_div_numerator,
    output logic [BW-1:0]          o_div_denominator,
    input  logic                   i_div_busy,
    input  logic                   i_div_valid,
    input  logic                   i_div_err,
    input  logic [BW-1:0]          i_div_quotient,
    input  logic [DIV_FLAGS_W-1:0] i_div_flags
);

    localparam logic [LGTO-1:0] c_timeout = LGTO'(TIMEOUT);

    arb_state_e             r_state;
    owner_e                 r_owner;
    owner_e                 r_favour;
    logic [LGTO-1:0]        r_cnt;
    logic                   r_div_wr;
    logic                   r_div_signed;
    logic [BW-1:0]          r_div_numerator;
    logic [BW-1:0]          r_div_denominator;
    logic                   r_a_valid;
    logic                   r_a_err;
    logic [BW-1:0]          r_a_quotient;
    logic [DIV_FLAGS_W-1:0] r_a_flags;
    logic                   r_b_valid;
    logic                   r_b_err;
    logic [BW-1:0]          r_b_quotient;
    logic [DIV_FLAGS_W-1:0] r_b_flags;

    logic                   w_a_signed;
    logic [BW-1:0]          w_a_numerator;
    logic [BW-1:0]          w_a_denominator;
    logic                   w_b_signed;
    logic [BW-1:0]          w_b_numerator;
    logic [BW-1:0]          w_b_denominator;
    logic                   w_done;
    logic                   w_timeout;
    logic                   w_finish;
    logic                   w_a_clear;
    logic                   w_b_clear;
    owner_e                 w_grant;

    assign w_done    = (r_state == ST_WAIT) && i_div_valid;
    assign w_timeout = (TIMEOUT != 0) && (r_state == ST_WAIT) && !i_div_valid
                       && (r_cnt == c_timeout);
    assign w_finish  = w_done || w_timeout;
    assign w_a_clear = w_finish && (r_owner == OWNER_A);
    assign w_b_clear = w_finish && (r_owner == OWNER_B);
    assign w_grant   = rr_pick(o_a_busy, o_b_busy, r_favour);

    div_req_slot #(.BW(BW)) u_slot_a (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wr          (i_a_wr),
        .i_clear       (w_a_clear),
        .i_signed      (i_a_signed),
        .i_numerator   (i_a_numerator),
        .i_denominator (i_a_denominator),
        .o_busy        (o_a_busy),
        .o_signed      (w_a_signed),
        .o_numerator   (w_a_numerator),
        .o_denominator (w_a_denominator)
    );

    div_req_slot #(.BW(BW)) u_slot_b (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wr          (i_b_wr),
        .i_clear       (w_b_clear),
        .i_signed      (i_b_signed),
        .i_numerator   (i_b_numerator),
        .i_denominator (i_b_denominator),
        .o_busy        (o_b_busy),
        .o_signed      (w_b_signed),
        .o_numerator   (w_b_numerator),
        .o_denominator (w_b_denominator)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state           <= ST_IDLE;
            r_owner           <= OWNER_A;
            r_favour          <= OWNER_A;
            r_cnt             <= '0;
            r_div_wr          <= 1'b0;
            r_div_signed      <= 1'b0;
            r_div_numerator   <= '0;
            r_div_denominator <= '0;
            r_a_valid         <= 1'b0;
            r_a_err           <= 1'b0;
            r_a_quotient      <= '0;
            r_a_flags         <= '0;
            r_b_valid         <= 1'b0;
            r_b_err           <= 1'b0;
            r_b_quotient      <= '0;
            r_b_flags         <= '0;
        end else begin
            r_div_wr  <= 1'b0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if ((o_a_busy || o_b_busy) && !i_div_busy) begin
                        r_div_wr <= 1'b1;
                        r_owner  <= w_grant;
                        r_cnt    <= '0;
                        r_state  <= ST_WAIT;
                        if (w_grant == OWNER_B) begin
                            r_div_signed      <= w_b_signed;
                            r_div_numerator   <= w_b_numerator;
                            r_div_denominator <= w_b_denominator;
                        end else begin
                            r_div_signed      <= w_a_signed;
                            r_div_numerator   <= w_a_numerator;
                            r_div_denominator <= w_a_denominator;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + LGTO'(1);
                    if (w_finish) begin
                        r_favour <= other_owner(r_owner);
                        r_state  <= w_done ? ST_IDLE : ST_DRAIN;
                        // A timeout reports an error with a zeroed result.
                        if (r_owner == OWNER_A) begin
                            r_a_valid    <= 1'b1;
                            r_a_err      <= w_done ? i_div_err : 1'b1;
                            r_a_quotient <= w_done ? i_div_quotient : '0;
                            r_a_flags    <= w_done ? i_div_flags : '0;
                        end else begin
                            r_b_valid    <= 1'b1;
                            r_b_err      <= w_done ? i_div_err : 1'b1;
                            r_b_quotient <= w_done ? i_div_quotient : '0;
                            r_b_flags    <= w_done ? i_div_flags : '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Swallow the late result of the abandoned operation.
                    if (!i_div_busy && !i_div_valid)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_div_wr          = r_div_wr;
    assign o_div_signed      = r_div_signed;
    assign o_div_numerator   = r_div_numerator;
    assign o_div_denominator = r_div_denominator;
    assign o_a_valid         = r_a_valid;
    assign o_a_err           = r_a_err;
    assign o_a_quotient      = r_a_quotient;
    assign o_a_flags         = r_a_flags;
    assign o_b_valid         = r_b_valid;
    assign o_b_err           = r_b_err;
    assign o_b_quotient      = r_b_quotient;
    assign o_b_flags         = r_b_flags;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_arbiter
// Description : Directed bench for div_arbiter with a behavioural divider.
// Revision    : 1.0
// ============================================================================
module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_wr = 1'b0, b_wr = 1'b0, a_sgn = 1'b0, b_sgn = 1'b0;
    logic [31:0] a_num = '0, a_den = '0, b_num = '0, b_den = '0;
    logic        div_busy = 1'b0, div_valid = 1'b0, div_err = 1'b0;
    logic [31:0] div_q = '0;
    logic [3:0]  div_f = '0;

    logic        o_a_busy, o_a_valid, o_a_err, o_b_busy, o_b_valid, o_b_err;
    logic [31:0] o_a_quotient, o_b_quotient, o_div_numerator, o_div_denominator;
    logic [3:0]  o_a_flags, o_b_flags;
    logic        o_div_wr, o_div_signed;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stub_lat = 1;

    div_arbiter #(.BW(32), .TIMEOUT(8), .LGTO(7)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_wr(a_wr), .i_a_signed(a_sgn), .i_a_numerator(a_num), .i_a_denominator(a_den),
        .o_a_busy(o_a_busy), .o_a_valid(o_a_valid), .o_a_err(o_a_err),
        .o_a_quotient(o_a_quotient), .o_a_flags(o_a_flags),
        .i_b_wr(b_wr), .i_b_signed(b_sgn), .i_b_numerator(b_num), .i_b_denominator(b_den),
        .o_b_busy(o_b_busy), .o_b_valid(o_b_valid), .o_b_err(o_b_err),
        .o_b_quotient(o_b_quotient), .o_b_flags(o_b_flags),
        .o_div_wr(o_div_wr), .o_div_signed(o_div_signed),
        .o_div_numerator(o_div_numerator), .o_div_denominator(o_div_denominator),
        .i_div_busy(div_busy), .i_div_valid(div_valid), .i_div_err(div_err),
        .i_div_quotient(div_q), .i_div_flags(div_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural divider: busy while counting down, one-cycle valid at the end.
    initial begin : stub
        int          cnt;
        logic        r, sg;
        logic [31:0] n, d;
        cnt = 0; sg = 1'b0; n = '0; d = '0;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            div_valid = 1'b0;
            div_err   = 1'b0;
            if (r) begin
                cnt      = 0;
                div_busy = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        div_busy  = 1'b0;
                        div_valid = 1'b1;
                        if (d == 0) begin
                            div_err = 1'b1;
                            div_q   = '0;
                        end else if (sg)
                            div_q = $signed(n) / $signed(d);
                        else
                            div_q = n / d;
                        div_f = {2'b00, div_q[31], div_q == 32'd0};
                    end
                end
                if (o_div_wr && cnt == 0) begin
                    cnt = stub_lat; div_busy = 1'b1;
                    sg = o_div_signed; n = o_div_numerator; d = o_div_denominator;
                end
            end
        end
    end

    // Protocol monitors: busy/valid exclusive, no strobe while busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_a_valid === 1'b1) chk("a_busy_with_valid", o_a_busy, 0);
            if (o_b_valid === 1'b1) chk("b_busy_with_valid", o_b_busy, 0);
            if (a_wr) chk("a_wr_while_busy", o_a_busy, 0);
            if (b_wr) chk("b_wr_while_busy", o_b_busy, 0);
        end
    end

    task automatic wait_valid(input bit sel, input int budget, input string nm, output int vc);
        vc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel ? o_b_valid : o_a_valid) === 1'b1) begin
                vc = cyc;
                break;
            end
        end
        if (vc < 0) chk({nm, "_valid_timeout"}, 0, 1);
    endtask

    task automatic wait_wr(input int budget, input string nm, output int wc);
        wc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_div_wr === 1'b1) begin
                wc = cyc;
                break;
            end
        end
        if (wc < 0) chk({nm, "_wr_timeout"}, 0, 1);
    endtask

    typedef struct {
        bit          sel;
        bit          sgn;
        logic [31:0] num;
        logic [31:0] den;
        int          lat;
        logic [31:0] q;
        logic [3:0]  f;
        bit          err;
    } vec_t;

    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] oq;
        logic [3:0]  of;
        int          n, vc;
        oq = v.sel ? o_a_quotient : o_b_quotient;
        of = v.sel ? o_a_flags : o_b_flags;
        stub_lat = v.lat;
        if (v.sel) begin
            b_sgn = v.sgn; b_num = v.num; b_den = v.den; b_wr = 1'b1;
        end else begin
            a_sgn = v.sgn; a_num = v.num; a_den = v.den; a_wr = 1'b1;
        end
        n = cyc;
        tick();
        a_wr = 1'b0; b_wr = 1'b0;
        chk({nm, "_busy"}, v.sel ? o_b_busy : o_a_busy, 1);
        tick();
        chk({nm, "_div_wr"}, o_div_wr, 1);
        chk({nm, "_div_signed"}, o_div_signed, v.sgn);
        chk({nm, "_div_num"}, o_div_numerator, v.num);
        chk({nm, "_div_den"}, o_div_denominator, v.den);
        wait_valid(v.sel, v.lat + 10, nm, vc);
        chk({nm, "_latency"}, vc, n + 2 + v.lat + 1);
        chk({nm, "_quot"}, v.sel ? o_b_quotient : o_a_quotient, v.q);
        chk({nm, "_flags"}, v.sel ? o_b_flags : o_a_flags, v.f);
        chk({nm, "_err"}, v.sel ? o_b_err : o_a_err, v.err);
        chk({nm, "_busy_low"}, v.sel ? o_b_busy : o_a_busy, 0);
        chk({nm, "_other_quot"}, v.sel ? o_a_quotient : o_b_quotient, oq);
        chk({nm, "_other_flags"}, v.sel ? o_a_flags : o_b_flags, of);
        tick();
        chk({nm, "_valid_pulse"}, v.sel ? o_b_valid : o_a_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        vec_t rv;
        int   n, g, va, vb, wc;
        bit   bad;

        vecs[0] = '{sel:0, sgn:0, num:32'd100,        den:32'd7,          lat:3, q:32'd14,         f:4'b0000, err:0};
        vecs[1] = '{sel:1, sgn:1, num:32'hFFFFFFEC,   den:32'd3,          lat:2, q:32'hFFFFFFFA,   f:4'b0010, err:0};
        vecs[2] = '{sel:1, sgn:0, num:32'd9,          den:32'd0,          lat:1, q:32'd0,          f:4'b0001, err:1};
        vecs[3] = '{sel:0, sgn:0, num:32'd5,          den:32'd9,          lat:4, q:32'd0,          f:4'b0001, err:0};
        vecs[4] = '{sel:1, sgn:0, num:32'hFFFFFFFF,   den:32'd1,          lat:5, q:32'hFFFFFFFF,   f:4'b0010, err:0};
        vecs[5] = '{sel:0, sgn:1, num:32'hFFFFFF9C,   den:32'hFFFFFFF9,   lat:1, q:32'd14,         f:4'b0000, err:0};

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_busy", {o_a_busy, o_b_busy}, 0);
        chk("rst_valid", {o_a_valid, o_b_valid, o_a_err, o_b_err}, 0);
        chk("rst_div", {o_div_wr, o_div_signed, o_div_numerator}, 0);
        chk("rst_quot", {o_a_quotient, o_b_quotient}, 0);
        chk("rst_flags", {o_a_flags, o_b_flags, o_div_denominator}, 0);
        tick();

        // Simultaneous first requests: A wins, B follows A's valid
        stub_lat = 2;
        a_sgn = 1'b1; a_num = 32'hFFFFFFEC; a_den = 32'd3; a_wr = 1'b1;
        b_sgn = 1'b0; b_num = 32'd9; b_den = 32'd3; b_wr = 1'b1;
        tick();
        a_wr = 1'b0; b_wr = 1'b0;
        tick();
        chk("s1_wr", o_div_wr, 1);
        chk("s1_a_signed", o_div_signed, 1);
        chk("s1_a_first", o_div_numerator, 32'hFFFFFFEC);
        wait_valid(0, 20, "s1_a", va);
        chk("s1_a_quot", o_a_quotient, 32'hFFFFFFFA);
        chk("s1_b_still_busy", o_b_busy, 1);
        wait_wr(20, "s1_b", wc);
        chk("s1_b_wr_cycle", wc, va + 1);
        chk("s1_b_num", o_div_numerator, 32'd9);
        wait_valid(1, 20, "s1_b", vb);
        chk("s1_b_quot", o_b_quotient, 32'd3);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            tick();
        end

        // A served last: simultaneous pair now grants B; B divides by zero
        stub_lat = 2;
        a_sgn = 1'b0; a_num = 32'd50; a_den = 32'd5; a_wr = 1'b1;
        b_sgn = 1'b0; b_num = 32'd7;  b_den = 32'd0; b_wr = 1'b1;
        tick();
        a_wr = 1'b0; b_wr = 1'b0;
        tick();
        chk("s2_wr", o_div_wr, 1);
        chk("s2_b_first", o_div_numerator, 32'd7);
        wait_valid(1, 20, "s2_b", vb);
        chk("s2_b_err", o_b_err, 1);
        chk("s2_b_quot", o_b_quotient, 32'd0);
        chk("s2_b_flags", o_b_flags, 4'b0001);
        wait_wr(20, "s2_a", wc);
        chk("s2_a_wr_cycle", wc, vb + 1);
        chk("s2_a_num", o_div_numerator, 32'd50);
        wait_valid(0, 20, "s2_a", va);
        chk("s2_a_quot", o_a_quotient, 32'd10);
        chk("s2_a_err", o_a_err, 0);
        tick();

        // A re-requests the cycle after its valid while B is pending
        stub_lat = 3;
        a_sgn = 1'b0; a_num = 32'd33; a_den = 32'd3; a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        tick();
        chk("s4_a_wr", o_div_wr, 1);
        b_sgn = 1'b0; b_num = 32'd8; b_den = 32'd2; b_wr = 1'b1;
        tick();
        b_wr = 1'b0;
        wait_valid(0, 20, "s4_a", va);
        chk("s4_a_quot", o_a_quotient, 32'd11);
        tick();
        chk("s4_b_grant", o_div_wr, 1);
        chk("s4_b_num", o_div_numerator, 32'd8);
        a_num = 32'd60; a_den = 32'd4; a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        chk("s4_a_rebusy", o_a_busy, 1);
        wait_valid(1, 20, "s4_b", vb);
        chk("s4_b_quot", o_b_quotient, 32'd4);
        wait_wr(20, "s4_a2", wc);
        chk("s4_a2_wr_cycle", wc, vb + 1);
        chk("s4_a2_num", o_div_numerator, 32'd60);
        wait_valid(0, 20, "s4_a2", va);
        chk("s4_a2_quot", o_a_quotient, 32'd15);
        tick();

        // Timeout: divider busy for 20 cycles, B waits for the drain
        stub_lat = 20;
        a_num = 32'd81; a_den = 32'd9; a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        tick();
        g = cyc;
        chk("s5_wr", o_div_wr, 1);
        b_num = 32'd12; b_den = 32'd4; b_wr = 1'b1;
        tick();
        b_wr = 1'b0;
        stub_lat = 2;
        wait_valid(0, 20, "s5_a", va);
        chk("s5_timeout_cycle", va, g + 9);
        chk("s5_a_err", o_a_err, 1);
        chk("s5_a_quot", o_a_quotient, 32'd0);
        chk("s5_a_flags", o_a_flags, 4'b0000);
        bad = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (o_a_valid || o_b_valid || o_div_wr) bad = 1'b1;
        end
        chk("s5_drain_quiet", bad, 0);
        chk("s5_b_pending", o_b_busy, 1);
        tick();
        chk("s5_b_wr_after_drain", o_div_wr, 1);
        chk("s5_b_num", o_div_numerator, 32'd12);
        wait_valid(1, 20, "s5_b", vb);
        chk("s5_b_quot", o_b_quotient, 32'd3);
        tick();

        // Reset while WAIT: no valid for the aborted operation
        stub_lat = 10;
        a_num = 32'd77; a_den = 32'd7; a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        tick();
        chk("s6_wr", o_div_wr, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_rst_busy", o_a_busy, 0);
        chk("s6_rst_wr", o_div_wr, 0);
        chk("s6_rst_valid", o_a_valid, 0);
        chk("s6_rst_b_quot", o_b_quotient, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_a_valid || o_b_valid || o_div_wr || o_a_busy) bad = 1'b1;
        end
        chk("s6_quiet", bad, 0);
        rv = '{sel:0, sgn:0, num:32'd77, den:32'd7, lat:2, q:32'd11, f:4'b0000, err:0};
        run_vec(rv, "s6_after");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
